stream_mux_rr: RTL and testbench

- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake; successor to the 4:1 combinational mux.
- Two run-time modes:
  - Select mode: an external select picks the channel.
  - Round-robin mode: an internal fair arbiter picks among requesting channels.
- Sits between multiple producer streams and a single consumer datapath; output registered for timing closure.

---
 rtl/stream_mux_pkg.sv | 21 ++
 rtl/rr_pick.sv | 33 +++
 rtl/stream_mux_rr.sv | 98 +++++++++
 tb/tb_stream_mux_rr.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream multiplexer family.
// Mode encodings and a constant clog2 used to size select/channel indices.
package stream_mux_pkg;

  localparam logic MODE_SELECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Minimum bits needed to index n items (n >= 2).
  function automatic int clog2(input int n);
    int bits;
    int v;
    bits = 0;
    v    = n - 1;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating find-first: picks the first set req bit after ptr, wrapping modulo CHANNELS.
// Purely combinational so it can be shared by other arbiters.
module rr_pick
  import stream_mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    gnt_idx,
  output logic                gnt_any
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

  logic [SEL_W-1:0] cur;

  // Walk ptr+1, ptr+2, ... with explicit wrap so non-power-of-2 counts never index past LAST.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cur     = ptr;
    for (int k = 0; k < CHANNELS; k++) begin
      cur = (cur == LAST) ? '0 : cur + SEL_W'(1);
      if (!gnt_any && req[cur]) begin
        gnt_any = 1'b1;
        gnt_idx = cur;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with select or round-robin channel choice.
// Single output register stage: accepts a new word whenever the register is empty or draining.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load;
  logic             sel_hit;
  logic             grant;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;

  rr_pick #(.CHANNELS(CHANNELS)) u_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Grant selection; an out-of-range select simply never grants.
  always_comb begin
    load    = !out_valid_q || out_ready;
    sel_hit = 1'b0;
    if (int'(select) < CHANNELS) begin
      sel_hit = in_valid[select];
    end
    grant    = (mode == MODE_RR) ? rr_any : sel_hit;
    gnt_idx  = (mode == MODE_RR) ? rr_idx : select;
    gnt_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        gnt_data = in_data[i*WIDTH +: WIDTH];
      end
    end
    // rst_n gates ready so no producer sees an accept while the register is held in reset.
    in_ready = (rst_n && load && grant) ? (CHANNELS'(1) << gnt_idx) : '0;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = grant;
      if (grant) begin
        out_data_d = gnt_data;
        out_chan_d = gnt_idx;
        if (mode == MODE_RR) begin
          ptr_d = gnt_idx;
        end
      end
    end
  end

  // Pointer resets to the last channel so the first round-robin search starts at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_W'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr: a 4-channel instance and a 3-channel
// instance (non-power-of-2 select range), driven with hand-computed expected values.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;

  logic [31:0] inData;
  logic [3:0]  inValid;
  logic [3:0]  inReady;
  logic        mode;
  logic [1:0]  select;
  logic [7:0]  outData;
  logic [1:0]  outChan;
  logic        outValid;
  logic        outReady;

  logic [23:0] inData3;
  logic [2:0]  inValid3;
  logic [2:0]  inReady3;
  logic        mode3;
  logic [1:0]  select3;
  logic [7:0]  outData3;
  logic [1:0]  outChan3;
  logic        outValid3;
  logic        outReady3;

  int checks;
  int errors;

  localparam logic [31:0] BASE_DATA  = 32'hD3A5B1C0;
  localparam logic [23:0] BASE_DATA3 = 24'h332211;

  logic [7:0] chData [4];
  logic [7:0] chData3 [3];
  logic [1:0] expSeq [4];

  stream_mux_rr #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (inData),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .mode      (mode),
    .select    (select),
    .out_data  (outData),
    .out_chan  (outChan),
    .out_valid (outValid),
    .out_ready (outReady)
  );

  stream_mux_rr #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (inData3),
    .in_valid  (inValid3),
    .in_ready  (inReady3),
    .mode      (mode3),
    .select    (select3),
    .out_data  (outData3),
    .out_chan  (outChan3),
    .out_valid (outValid3),
    .out_ready (outReady3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] sel, input logic [3:0] valid,
                               input logic oReady);
    mode     = m;
    select   = sel;
    inValid  = valid;
    outReady = oReady;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chData[0] = 8'hC0; chData[1] = 8'hB1; chData[2] = 8'hA5; chData[3] = 8'hD3;
    chData3[0] = 8'h11; chData3[1] = 8'h22; chData3[2] = 8'h33;
    expSeq[0] = 2'd1; expSeq[1] = 2'd3; expSeq[2] = 2'd1; expSeq[3] = 2'd3;

    rst_n     = 1'b0;
    inData    = $urandom;
    applyStimulus(1'($urandom), 2'($urandom), 4'hF, 1'b1);
    inData3   = 24'($urandom);
    inValid3  = 3'b111;
    mode3     = 1'b1;
    select3   = 2'($urandom);
    outReady3 = 1'b1;
    repeat (3) stepClk();

    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_out_data", 32'(outData), 32'd0);
    checkOutput("rst_out_chan", 32'(outChan), 32'd0);
    checkOutput("rst_in_ready", 32'(inReady), 32'd0);
    checkOutput("rst_in_ready3", 32'(inReady3), 32'd0);
    checkOutput("rst_out_valid3", 32'(outValid3), 32'd0);

    inData   = BASE_DATA;
    inData3  = BASE_DATA3;
    inValid3 = 3'b000;
    applyStimulus(1'b1, 2'd0, 4'hF, 1'b1);
    rst_n = 1'b1;
    #1;
    checkOutput("rr_first_ready", 32'(inReady), 32'b0001);

    for (int k = 0; k < 8; k++) begin
      stepClk();
      checkOutput($sformatf("rr_fair_chan%0d", k), 32'(outChan), 32'(k % 4));
      checkOutput($sformatf("rr_fair_data%0d", k), 32'(outData), 32'(chData[k % 4]));
      checkOutput($sformatf("rr_fair_valid%0d", k), 32'(outValid), 32'd1);
    end

    inValid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      stepClk();
      checkOutput($sformatf("rr_sparse_chan%0d", k), 32'(outChan), 32'(expSeq[k]));
    end

    applyStimulus(1'b0, 2'd2, 4'hF, 1'b1);
    #1;
    checkOutput("sel_ready", 32'(inReady), 32'b0100);
    stepClk();
    checkOutput("sel_data", 32'(outData), 32'hA5);
    checkOutput("sel_chan", 32'(outChan), 32'd2);
    checkOutput("sel_valid", 32'(outValid), 32'd1);

    outReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      select = 2'(k * 2 + 1);
      inData = ~BASE_DATA ^ 32'(k);
      #1;
      checkOutput($sformatf("stall_ready%0d", k), 32'(inReady), 32'd0);
      stepClk();
      checkOutput($sformatf("stall_data%0d", k), 32'(outData), 32'hA5);
      checkOutput($sformatf("stall_chan%0d", k), 32'(outChan), 32'd2);
      checkOutput($sformatf("stall_valid%0d", k), 32'(outValid), 32'd1);
    end
    inData = BASE_DATA;
    applyStimulus(1'b0, 2'd1, 4'hF, 1'b1);
    #1;
    checkOutput("drain_ready", 32'(inReady), 32'b0010);
    stepClk();
    checkOutput("drain_data", 32'(outData), 32'hB1);
    checkOutput("drain_chan", 32'(outChan), 32'd1);
    checkOutput("drain_valid", 32'(outValid), 32'd1);

    applyStimulus(1'b1, 2'd1, 4'hF, 1'b1);
    stepClk();
    checkOutput("msw_rr0", 32'(outChan), 32'd0);
    stepClk();
    checkOutput("msw_rr1", 32'(outChan), 32'd1);
    applyStimulus(1'b0, 2'd3, 4'hF, 1'b1);
    stepClk();
    checkOutput("msw_sel3a", 32'(outChan), 32'd3);
    checkOutput("msw_sel3_data", 32'(outData), 32'hD3);
    stepClk();
    checkOutput("msw_sel3b", 32'(outChan), 32'd3);
    applyStimulus(1'b1, 2'd3, 4'hF, 1'b1);
    #1;
    checkOutput("msw_resume_ready", 32'(inReady), 32'b0100);
    stepClk();
    checkOutput("msw_resume_chan", 32'(outChan), 32'd2);

    applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
    #1;
    checkOutput("idle_ready", 32'(inReady), 32'd0);
    stepClk();
    checkOutput("idle_valid", 32'(outValid), 32'd0);
    checkOutput("idle_data_hold", 32'(outData), 32'hA5);
    checkOutput("idle_chan_hold", 32'(outChan), 32'd2);

    inValid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      stepClk();
      checkOutput($sformatf("single_chan%0d", k), 32'(outChan), 32'd3);
      checkOutput($sformatf("single_valid%0d", k), 32'(outValid), 32'd1);
    end

    applyStimulus(1'b0, 2'd0, 4'b1000, 1'b1);
    #1;
    checkOutput("sel_novalid_ready", 32'(inReady), 32'd0);
    stepClk();
    checkOutput("sel_novalid_valid", 32'(outValid), 32'd0);
    checkOutput("sel_novalid_chan", 32'(outChan), 32'd3);

    inValid3 = 3'b111;
    mode3    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      stepClk();
      checkOutput($sformatf("c3_rr_chan%0d", k), 32'(outChan3), 32'(k % 3));
      checkOutput($sformatf("c3_rr_data%0d", k), 32'(outData3), 32'(chData3[k % 3]));
    end
    mode3   = 1'b0;
    select3 = 2'd2;
    #1;
    checkOutput("c3_sel2_ready", 32'(inReady3), 32'b100);
    stepClk();
    checkOutput("c3_sel2_chan", 32'(outChan3), 32'd2);
    select3 = 2'd3;
    #1;
    checkOutput("c3_sel3_ready", 32'(inReady3), 32'd0);
    stepClk();
    checkOutput("c3_sel3_valid", 32'(outValid3), 32'd0);
    checkOutput("c3_sel3_chan_hold", 32'(outChan3), 32'd2);

    applyStimulus(1'b1, 2'd0, 4'b1000, 1'b0);
    stepClk();
    checkOutput("arst_pre_valid", 32'(outValid), 32'd1);
    rst_n = 1'b0;
    #2;
    checkOutput("arst_valid", 32'(outValid), 32'd0);
    checkOutput("arst_data", 32'(outData), 32'd0);
    checkOutput("arst_ready", 32'(inReady), 32'd0);
    outReady = 1'b1;
    #1;
    checkOutput("arst_ready_load", 32'(inReady), 32'd0);
    stepClk();
    rst_n = 1'b1;
    stepClk();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
